// File: rtl/cam_initiator.sv
// CAM test initiator: writes NUM keys starting at key_base with data key^VAL_PATTERN,
// then reads each key back one at a time and counts read errors (mismatch or timeout).
//
// Ports:
//   clk, reset        sole clock, synchronous active-high reset
//   start, key_base   run request (sampled in idle) and first key of the run
//   busy, done        run in progress / single-cycle end-of-run pulse
//   err_count         saturating error count for the current run
//   err_valid,err_key single-cycle error pulse and key of the most recent error
//   valid_i, rw_n,    CAM request: valid, 0 = write / 1 = read, key, write data
//   key, val_i
//   valid_o, val_o    CAM read response
module cam_initiator #(
  parameter int unsigned      KEY_W       = 16,
  parameter int unsigned      VAL_W       = 16,
  parameter int unsigned      NUM         = 8,
  parameter logic [VAL_W-1:0] VAL_PATTERN = 16'hA5C3,
  parameter int unsigned      TIMEOUT     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [KEY_W-1:0] key_base,
  output logic             busy,
  output logic             done,
  output logic [7:0]       err_count,
  output logic             err_valid,
  output logic [KEY_W-1:0] err_key,
  output logic             valid_i,
  output logic             rw_n,
  output logic [KEY_W-1:0] key,
  output logic [VAL_W-1:0] val_i,
  input  logic             valid_o,
  input  logic [VAL_W-1:0] val_o
);

  localparam int unsigned      WaitW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [7:0]       LastIdx  = 8'(NUM - 1);
  localparam logic [WaitW-1:0] LastWait = WaitW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StReadReq,
    StReadWait,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       i_q, i_d;
  logic [KEY_W-1:0] key_base_q, key_base_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [7:0]       err_count_q, err_count_d;
  logic             err_valid_q, err_valid_d;
  logic [KEY_W-1:0] err_key_q, err_key_d;

  logic [KEY_W-1:0] cur_key;
  logic [VAL_W-1:0] exp_val;
  logic             err_event;
  logic             advance;

  // Key arithmetic wraps naturally at KEY_W bits.
  assign cur_key = key_base_q + KEY_W'(i_q);
  assign exp_val = VAL_W'(cur_key) ^ VAL_PATTERN;

  assign err_count = err_count_q;
  assign err_valid = err_valid_q;
  assign err_key   = err_key_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      i_q         <= '0;
      key_base_q  <= '0;
      wait_q      <= '0;
      err_count_q <= '0;
      err_valid_q <= 1'b0;
      err_key_q   <= '0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      key_base_q  <= key_base_d;
      wait_q      <= wait_d;
      err_count_q <= err_count_d;
      err_valid_q <= err_valid_d;
      err_key_q   <= err_key_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    key_base_d  = key_base_q;
    wait_d      = wait_q;
    err_count_d = err_count_q;
    err_key_d   = err_key_q;
    err_event   = 1'b0;
    advance     = 1'b0;
    busy        = (state_q != StIdle);
    done        = 1'b0;
    valid_i     = 1'b0;
    rw_n        = 1'b0;
    key         = '0;
    val_i       = '0;

    case (state_q)
      StIdle: begin
        if (start) begin
          key_base_d  = key_base;
          err_count_d = '0;
          i_d         = '0;
          state_d     = StWrite;
        end
      end
      StWrite: begin
        valid_i = 1'b1;
        key     = cur_key;
        val_i   = exp_val;
        if (i_q == LastIdx) begin
          i_d     = '0;
          state_d = StReadReq;
        end else begin
          i_d = i_q + 8'd1;
        end
      end
      StReadReq: begin
        valid_i = 1'b1;
        rw_n    = 1'b1;
        key     = cur_key;
        wait_d  = '0;
        state_d = StReadWait;
      end
      StReadWait: begin
        if (valid_o) begin
          err_event = (val_o != exp_val);
          advance   = 1'b1;
        end else if (wait_q == LastWait) begin
          // A missing response is scored exactly like a data mismatch.
          err_event = 1'b1;
          advance   = 1'b1;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
        if (advance) begin
          if (i_q == LastIdx) begin
            state_d = StDone;
          end else begin
            i_d     = i_q + 8'd1;
            state_d = StReadReq;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    err_valid_d = err_event;
    if (err_event) begin
      err_key_d = cur_key;
      if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
  end

endmodule
